// File: rtl/trap_controller.sv
// Machine-mode trap/MRET sequencer: writes mepc/mcause/mtval, reads mtvec or mepc,
// then issues a one-cycle PC redirect. trap_done is low while a sequence is in flight.
module trap_controller #(
  parameter int XLEN         = 32,
  parameter int MTVAL_ENABLE = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [2:0]      trap_status,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_bad_value,
  input  logic            csr_ready,
  input  logic [XLEN-1:0] csr_read_data,
  output logic            csr_trap_write,
  output logic [11:0]     csr_trap_address,
  output logic [XLEN-1:0] csr_trap_write_data,
  output logic            trap_redirect,
  output logic [XLEN-1:0] trap_target,
  output logic            trap_done,
  output logic [2:0]      dbg_state
);

  localparam logic [2:0] ST_NONE    = 3'd0;
  localparam logic [2:0] ST_ECALL   = 3'd1;
  localparam logic [2:0] ST_EBREAK  = 3'd2;
  localparam logic [2:0] ST_MRET    = 3'd3;
  localparam logic [2:0] ST_IMIS    = 3'd4;
  localparam logic [2:0] ST_LMIS    = 3'd5;
  localparam logic [2:0] ST_SMIS    = 3'd6;
  localparam logic [2:0] ST_ILLEGAL = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_MEPC, S_WR_MCAUSE, S_WR_MTVAL, S_RD_MTVEC, S_RD_MEPC, S_REDIRECT
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      status_q;
  logic [XLEN-1:0] pc_q, bad_q, target_q;
  logic [XLEN-1:0] cause_val, mtval_val;
  logic            unused_rd_low;

  assign unused_rd_low = ^csr_read_data[1:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      status_q <= ST_NONE;
      pc_q     <= '0;
      bad_q    <= '0;
      target_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && trap_status != ST_NONE) begin
        status_q <= trap_status;
        pc_q     <= trap_pc;
        bad_q    <= trap_bad_value;
      end
      if ((state_q == S_RD_MTVEC || state_q == S_RD_MEPC) && csr_ready) begin
        target_q <= {csr_read_data[XLEN-1:2], 2'b00};
      end
    end
  end

  // CSR handshake: each WR_*/RD_* state presents address (and strobe/data for writes)
  // and holds them until a posedge with csr_ready=1, which commits the access exactly once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (trap_status == ST_MRET)      state_d = S_RD_MEPC;
        else if (trap_status != ST_NONE) state_d = S_WR_MEPC;
      end
      S_WR_MEPC:   if (csr_ready) state_d = S_WR_MCAUSE;
      S_WR_MCAUSE: if (csr_ready) state_d = (MTVAL_ENABLE != 0) ? S_WR_MTVAL : S_RD_MTVEC;
      S_WR_MTVAL:  if (csr_ready) state_d = S_RD_MTVEC;
      S_RD_MTVEC:  if (csr_ready) state_d = S_REDIRECT;
      S_RD_MEPC:   if (csr_ready) state_d = S_REDIRECT;
      S_REDIRECT:  state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (status_q)
      ST_IMIS:    cause_val = XLEN'(0);
      ST_ILLEGAL: cause_val = XLEN'(2);
      ST_EBREAK:  cause_val = XLEN'(3);
      ST_LMIS:    cause_val = XLEN'(4);
      ST_SMIS:    cause_val = XLEN'(6);
      default:    cause_val = XLEN'(11);
    endcase
    if (status_q >= ST_IMIS)        mtval_val = bad_q;
    else if (status_q == ST_EBREAK) mtval_val = pc_q;
    else                            mtval_val = '0;
  end

  always_comb begin
    csr_trap_write      = 1'b0;
    csr_trap_address    = 12'h000;
    csr_trap_write_data = '0;
    trap_redirect       = 1'b0;
    trap_done           = 1'b0;
    case (state_q)
      S_IDLE: trap_done = (trap_status == ST_NONE);
      S_WR_MEPC: begin
        csr_trap_write      = 1'b1;
        csr_trap_address    = 12'h341;
        csr_trap_write_data = {pc_q[XLEN-1:2], 2'b00};
      end
      S_WR_MCAUSE: begin
        csr_trap_write      = 1'b1;
        csr_trap_address    = 12'h342;
        csr_trap_write_data = cause_val;
      end
      S_WR_MTVAL: begin
        csr_trap_write      = 1'b1;
        csr_trap_address    = 12'h343;
        csr_trap_write_data = mtval_val;
      end
      S_RD_MTVEC: csr_trap_address = 12'h305;
      S_RD_MEPC:  csr_trap_address = 12'h341;
      S_REDIRECT: begin
        trap_redirect = 1'b1;
        trap_done     = 1'b1;
      end
      default: ;
    endcase
  end

  assign trap_target = target_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_trap_controller.sv
// Bench for trap_controller: two instances (mtval on/off), a small CSR-file model with
// programmable ready stalls, and a scoreboard of expected CSR writes per trap.
module tb_trap_controller;

  localparam logic [2:0] S_NONE = 3'd0, S_ECALL = 3'd1, S_EBREAK = 3'd2, S_MRET = 3'd3;
  localparam logic [2:0] S_IMIS = 3'd4, S_LMIS = 3'd5, S_SMIS = 3'd6, S_ILL = 3'd7;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  ts_a = S_NONE, ts_b = S_NONE;
  logic [31:0] tpc = '0, tbad = '0;
  logic        rdy_a, rdy_b, wr_a, wr_b, redir_a, redir_b, done_a, done_b;
  logic [31:0] rdata_a, rdata_b, wdata_a, wdata_b, tgt_a, tgt_b;
  logic [11:0] addr_a, addr_b;
  logic [2:0]  unused_dbg_a, unused_dbg_b;

  trap_controller #(.XLEN(32), .MTVAL_ENABLE(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .trap_status(ts_a), .trap_pc(tpc), .trap_bad_value(tbad),
    .csr_ready(rdy_a), .csr_read_data(rdata_a), .csr_trap_write(wr_a),
    .csr_trap_address(addr_a), .csr_trap_write_data(wdata_a), .trap_redirect(redir_a),
    .trap_target(tgt_a), .trap_done(done_a), .dbg_state(unused_dbg_a));

  trap_controller #(.XLEN(32), .MTVAL_ENABLE(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .trap_status(ts_b), .trap_pc(tpc), .trap_bad_value(tbad),
    .csr_ready(rdy_b), .csr_read_data(rdata_b), .csr_trap_write(wr_b),
    .csr_trap_address(addr_b), .csr_trap_write_data(wdata_b), .trap_redirect(redir_b),
    .trap_target(tgt_b), .trap_done(done_b), .dbg_state(unused_dbg_b));

  // CSR file models: ready drops for stall_n cycles of accesses to stall_addr
  logic [11:0] stall_addr = 12'h000;
  int          stall_n = 0;
  logic        preload = 1'b0;
  logic [31:0] pre_mtvec = '0, pre_mepc = '0;
  logic [31:0] mtvec_a, mepc_a, mcause_a, mtval_a, mtvec_b, mepc_b, mcause_b, mtval_b;
  int          used_a = 0, used_b = 0;

  assign rdy_a = !(addr_a == stall_addr && used_a < stall_n);
  assign rdy_b = !(addr_b == stall_addr && used_b < stall_n);
  assign rdata_a = (addr_a == 12'h305) ? mtvec_a : (addr_a == 12'h341) ? mepc_a :
                   (addr_a == 12'h342) ? mcause_a : (addr_a == 12'h343) ? mtval_a : 32'hDEAD_BEEF;
  assign rdata_b = (addr_b == 12'h305) ? mtvec_b : (addr_b == 12'h341) ? mepc_b :
                   (addr_b == 12'h342) ? mcause_b : (addr_b == 12'h343) ? mtval_b : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (preload) begin
      mtvec_a <= pre_mtvec; mepc_a <= pre_mepc; mcause_a <= '0; mtval_a <= '0;
    end else if (wr_a && rdy_a) begin
      case (addr_a)
        12'h305: mtvec_a  <= wdata_a;
        12'h341: mepc_a   <= wdata_a;
        12'h342: mcause_a <= wdata_a;
        12'h343: mtval_a  <= wdata_a;
        default: ;
      endcase
    end
    if (addr_a == 12'h000) used_a <= 0;
    else if (addr_a == stall_addr && used_a < stall_n) used_a <= used_a + 1;
  end

  always @(posedge clk) begin
    if (preload) begin
      mtvec_b <= pre_mtvec; mepc_b <= pre_mepc; mcause_b <= '0; mtval_b <= '0;
    end else if (wr_b && rdy_b) begin
      case (addr_b)
        12'h305: mtvec_b  <= wdata_b;
        12'h341: mepc_b   <= wdata_b;
        12'h342: mcause_b <= wdata_b;
        12'h343: mtval_b  <= wdata_b;
        default: ;
      endcase
    end
    if (addr_b == 12'h000) used_b <= 0;
    else if (addr_b == stall_addr && used_b < stall_n) used_b <= used_b + 1;
  end

  // scoreboard
  logic [43:0] exp_q[$];
  logic [43:0] got_q[$];
  logic [31:0] ref_mtvec = '0;
  logic [31:0] ref_mepc [2];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cause_of(input logic [2:0] st);
    case (st)
      S_ECALL:  return 32'd11;
      S_EBREAK: return 32'd3;
      S_IMIS:   return 32'd0;
      S_LMIS:   return 32'd4;
      S_SMIS:   return 32'd6;
      S_ILL:    return 32'd2;
      default:  return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] mtval_of(input logic [2:0] st, input logic [31:0] pc,
                                           input logic [31:0] bad);
    if (st == S_ECALL) return 32'd0;
    if (st == S_EBREAK) return pc;
    return bad;
  endfunction

  function automatic logic o_wr(input int s);           return (s == 0) ? wr_a : wr_b;       endfunction
  function automatic logic o_rdy(input int s);          return (s == 0) ? rdy_a : rdy_b;     endfunction
  function automatic logic o_redir(input int s);        return (s == 0) ? redir_a : redir_b; endfunction
  function automatic logic o_done(input int s);         return (s == 0) ? done_a : done_b;   endfunction
  function automatic logic [11:0] o_addr(input int s);  return (s == 0) ? addr_a : addr_b;   endfunction
  function automatic logic [31:0] o_wdata(input int s); return (s == 0) ? wdata_a : wdata_b; endfunction
  function automatic logic [31:0] o_tgt(input int s);   return (s == 0) ? tgt_a : tgt_b;     endfunction

  task automatic set_st(input int s, input logic [2:0] st);
    if (s == 0) ts_a = st;
    else        ts_b = st;
  endtask

  task automatic preload_regs(input logic [31:0] vt, input logic [31:0] ep);
    pre_mtvec = vt; pre_mepc = ep; preload = 1'b1;
    @(posedge clk); #1;
    preload = 1'b0;
    ref_mtvec = vt; ref_mepc[0] = ep; ref_mepc[1] = ep;
  endtask

  // One trap or MRET on instance sel; cycle 0 is the IDLE cycle that sees the status.
  task automatic do_trap(input int sel, input logic [2:0] st, input logic [31:0] pc,
                         input logic [31:0] bad, input logic [11:0] s_addr, input int s_cnt,
                         input bit junk, input string tag);
    logic [31:0] exp_tgt;
    int exp_lat, exp_wcyc, cyc, wcyc, stall_w, stall_r;
    bit seen, mt;
    mt = (sel == 0);
    exp_q.delete(); got_q.delete();
    stall_w = 0; stall_r = 0;
    if (st == S_MRET) begin
      exp_tgt = ref_mepc[sel] & ~32'h3;
      if (s_addr == 12'h341) stall_r = s_cnt;
      exp_lat = 2 + stall_r;
    end else begin
      ref_mepc[sel] = pc & ~32'h3;
      exp_q.push_back({12'h341, pc & ~32'h3});
      exp_q.push_back({12'h342, cause_of(st)});
      if (mt) exp_q.push_back({12'h343, mtval_of(st, pc, bad)});
      exp_tgt = ref_mtvec & ~32'h3;
      if (s_addr == 12'h341 || s_addr == 12'h342 || (mt && s_addr == 12'h343)) stall_w = s_cnt;
      if (s_addr == 12'h305) stall_r = s_cnt;
      exp_lat = exp_q.size() + 2 + stall_w + stall_r;
    end
    exp_wcyc = exp_q.size() + stall_w;

    stall_addr = s_addr; stall_n = s_cnt;
    tpc = pc; tbad = bad;
    set_st(sel, st);
    if (o_redir(sel)) begin @(posedge clk); #1; end
    #1;
    check({tag, "_done_seen"}, 64'(o_done(sel)), 64'd0);
    cyc = 0; wcyc = 0; seen = 1'b0;
    while (!seen && cyc < 60) begin
      if (o_wr(sel)) wcyc++;
      if (o_wr(sel) && o_rdy(sel)) got_q.push_back({o_addr(sel), o_wdata(sel)});
      @(posedge clk); #1;
      cyc++;
      set_st(sel, junk ? 3'($urandom_range(0, 7)) : S_NONE);
      tpc = $urandom; tbad = $urandom;
      #1;
      if (o_redir(sel)) seen = 1'b1;
      else check({tag, "_done_busy"}, 64'(o_done(sel)), 64'd0);
      if (!o_wr(sel)) check({tag, "_wdata_zero"}, 64'(o_wdata(sel)), 64'd0);
    end
    set_st(sel, S_NONE);
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_target"}, 64'(o_tgt(sel)), 64'(exp_tgt));
    check({tag, "_done_redir"}, 64'(o_done(sel)), 64'd1);
    check({tag, "_addr_redir"}, 64'(o_addr(sel)), 64'd0);
    check({tag, "_wr_cycles"}, 64'(wcyc), 64'(exp_wcyc));
    check({tag, "_n_writes"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check({tag, "_write"}, (i < got_q.size()) ? 64'(got_q[i]) : 64'hFFFF_FFFF_FFFF, 64'(exp_q[i]));
    end
    stall_n = 0;
  endtask

  task automatic reset_mid();
    int cyc, noisy;
    got_q.delete();
    stall_addr = 12'h342; stall_n = 5;
    tpc = 32'h0000_0400; tbad = '0; ts_a = S_ECALL;
    cyc = 0;
    #1;
    while (addr_a != 12'h342 && cyc < 20) begin
      if (wr_a && rdy_a) got_q.push_back({addr_a, wdata_a});
      @(posedge clk); #1;
      ts_a = S_NONE; cyc++;
      #1;
    end
    check("rst_in_mcause", 64'(addr_a), 64'h342);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("rst_done", 64'(done_a), 64'd1);
    check("rst_redir", 64'(redir_a), 64'd0);
    check("rst_wr", 64'(wr_a), 64'd0);
    check("rst_addr", 64'(addr_a), 64'd0);
    check("rst_tgt", 64'(tgt_a), 64'd0);
    reset_n = 1'b1; stall_n = 0;
    noisy = 0;
    repeat (8) begin
      if (wr_a || redir_a) noisy++;
      @(posedge clk); #1;
    end
    check("rst_quiet", 64'(noisy), 64'd0);
    check("rst_n_writes", 64'(got_q.size()), 64'd1);
    check("rst_mepc", (got_q.size() > 0) ? 64'(got_q[0]) : 64'd0, 64'({12'h341, 32'h0000_0400}));
    ref_mepc[0] = 32'h0000_0400;
  endtask

  initial begin
    ref_mepc[0] = '0; ref_mepc[1] = '0;
    reset_n = 1'b0;
    pre_mtvec = 32'h0000_2001; pre_mepc = '0; preload = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    preload = 1'b0;
    ref_mtvec = 32'h0000_2001;
    check("reset_done_a", 64'(done_a), 64'd1);
    check("reset_done_b", 64'(done_b), 64'd1);
    check("reset_wr_a", 64'(wr_a), 64'd0);
    check("reset_wr_b", 64'(wr_b), 64'd0);
    check("reset_addr_a", 64'(addr_a), 64'd0);
    check("reset_addr_b", 64'(addr_b), 64'd0);
    check("reset_wdata_a", 64'(wdata_a), 64'd0);
    check("reset_wdata_b", 64'(wdata_b), 64'd0);
    check("reset_redir_a", 64'(redir_a), 64'd0);
    check("reset_redir_b", 64'(redir_b), 64'd0);
    check("reset_tgt_a", 64'(tgt_a), 64'd0);
    check("reset_tgt_b", 64'(tgt_b), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle_done_a", 64'(done_a), 64'd1);

    do_trap(0, S_ECALL, 32'h0000_0100, 32'hAAAA_5555, 12'h000, 0, 1'b0, "ecall");
    do_trap(0, S_LMIS, 32'h0000_0204, 32'h0000_1003, 12'h342, 3, 1'b0, "lmis_stall");
    preload_regs(32'h0000_2001, 32'h0000_0208);
    do_trap(0, S_MRET, 32'h0000_0900, 32'h0, 12'h000, 0, 1'b0, "mret");
    do_trap(1, S_EBREAK, 32'h0000_0300, 32'h0, 12'h000, 0, 1'b0, "ebreak_nomtval");
    @(posedge clk); #1;
    reset_mid();
    do_trap(0, S_ECALL, 32'h0000_0500, 32'h0, 12'h000, 0, 1'b1, "ecall_junk");
    do_trap(0, S_ECALL, 32'h0000_0600, 32'h0, 12'h000, 0, 1'b0, "ecall_b2b");
    do_trap(0, S_MRET, 32'h0, 32'h0, 12'h341, 2, 1'b0, "mret_stall");

    for (int k = 0; k < 40; k++) begin
      int          sel, sc;
      logic [2:0]  st;
      logic [11:0] sa;
      if (k == 20) preload_regs($urandom, $urandom);
      sel = $urandom_range(0, 1);
      st  = 3'($urandom_range(1, 7));
      case ($urandom_range(0, 3))
        0:       sa = 12'h341;
        1:       sa = 12'h342;
        2:       sa = 12'h343;
        default: sa = 12'h305;
      endcase
      sc = $urandom_range(0, 3);
      do_trap(sel, st, $urandom, $urandom, sa, sc, $urandom_range(0, 1) == 1, "rnd");
      if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
